// File: rtl/shift_rotator_if.sv
// Operand/result bus for the 16-bit right shifter/rotator.
// The master drives operands; the slave returns the registered result.
interface shift_rotator_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned AMT_W  = 4;

  logic              vld_in;
  logic [DATA_W-1:0] src;
  logic              rotate;
  logic [AMT_W-1:0]  amt;
  logic [DATA_W-1:0] res;
  logic              vld_out;

  modport master (output vld_in, src, rotate, amt, input res, vld_out);
  modport slave  (input vld_in, src, rotate, amt, output res, vld_out);
endinterface

// File: rtl/shift_rotator.sv
// 16-bit logical-right shifter / right rotator built from four cascaded mux stages.
// Define SHIFT_ROTATOR_PIPE_EN to add a register between the 2- and 4-position stages (latency 2).
module shift_rotator (
  input  logic          clk,
  input  logic          rst,
  shift_rotator_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned HI_W   = 2;

  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] s2;
  logic [DATA_W-1:0] s4;
  logic [DATA_W-1:0] s8;

  logic [DATA_W-1:0] b_data;
  logic [HI_W-1:0]   b_amt;
  logic              b_rot;
  logic              b_vld;

  // Front stages: 1 and 2 positions, fill is zero or the wrapped low bits.
  always_comb begin
    s1 = bus.amt[0] ? {(bus.rotate ? bus.src[0] : 1'b0), bus.src[DATA_W-1:1]} : bus.src;
    s2 = bus.amt[1] ? {(bus.rotate ? s1[1:0] : 2'b00), s1[DATA_W-1:2]} : s1;
  end

`ifdef SHIFT_ROTATOR_PIPE_EN
  logic [DATA_W-1:0] p_data;
  logic [HI_W-1:0]   p_amt;
  logic              p_rot;
  logic              p_vld;

  // Mid-pipe register; operands with rst high are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_data <= '0;
      p_amt  <= '0;
      p_rot  <= 1'b0;
      p_vld  <= 1'b0;
    end else begin
      p_vld <= bus.vld_in;
      if (bus.vld_in) begin
        p_data <= s2;
        p_amt  <= bus.amt[3:2];
        p_rot  <= bus.rotate;
      end
    end
  end

  assign b_data = p_data;
  assign b_amt  = p_amt;
  assign b_rot  = p_rot;
  assign b_vld  = p_vld;
`else
  assign b_data = s2;
  assign b_amt  = bus.amt[3:2];
  assign b_rot  = bus.rotate;
  assign b_vld  = bus.vld_in;
`endif

  // Back stages: 4 and 8 positions.
  always_comb begin
    s4 = b_amt[0] ? {(b_rot ? b_data[3:0] : 4'h0), b_data[DATA_W-1:4]} : b_data;
    s8 = b_amt[1] ? {(b_rot ? s4[7:0] : 8'h00), s4[DATA_W-1:8]} : s4;
  end

  // Output register: result holds while idle, strobe lasts one cycle per operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res     <= '0;
      bus.vld_out <= 1'b0;
    end else begin
      bus.vld_out <= b_vld;
      if (b_vld) begin
        bus.res <= s8;
      end
    end
  end
endmodule

// File: tb/tb_shift_rotator.sv
// Scoreboard bench for shift_rotator: driver pushes expected results, monitor pops on vld_out.
module tb_shift_rotator;
`ifdef SHIFT_ROTATOR_PIPE_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef struct {
    logic [15:0] exp;
    int unsigned cyc;
    string       name;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;
  logic [15:0] last_res = 16'h0000;
  item_t q[$];

  shift_rotator_if bus ();

  shift_rotator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference: per-bit index arithmetic rather than a mux cascade.
  function automatic logic [15:0] ref_model(input logic [15:0] s, input logic r, input logic [3:0] a);
    logic [15:0] o;
    int j;
    o = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      j = i + int'(a);
      if (j < 16) o[i] = s[j];
      else if (r) o[i] = s[j-16];
      else o[i] = 1'b0;
    end
    return o;
  endfunction

  // Monitor: every vld_out pulse must match the oldest pending operand at the right latency.
  always @(posedge clk) begin
    item_t it;
    #1;
    if (bus.vld_out === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL extra_pulse: vld_out=1 res=%h but nothing expected", bus.res);
      end else begin
        it = q.pop_front();
        if (bus.res !== it.exp || (cyc - it.cyc) != LAT) begin
          bad++;
          $display("FAIL %s: res=%h latency=%0d, expected res=%h latency=%0d",
                   it.name, bus.res, cyc - it.cyc, it.exp, LAT);
        end
        last_res = it.exp;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input string name, input logic [15:0] s, input logic r,
                       input logic [3:0] a, input logic [15:0] exp);
    item_t it;
    @(negedge clk);
    bus.vld_in = 1'b1;
    bus.src    = s;
    bus.rotate = r;
    bus.amt    = a;
    it.exp  = exp;
    it.cyc  = cyc;
    it.name = name;
    q.push_back(it);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.vld_in = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] s;
    logic        r;
    logic [3:0]  a;
    rst        = 1'b1;
    bus.vld_in = 1'b0;
    bus.src    = 16'h0000;
    bus.rotate = 1'b0;
    bus.amt    = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_res", bus.res, 16'h0000);
    check("reset_vld", 16'(bus.vld_out), 16'h0000);
    rst = 1'b0;

    // Hand-computed directed vectors, issued back to back.
    issue("shr1_8001",  16'h8001, 1'b0, 4'd1,  16'h4000);
    issue("rot1_8001",  16'h8001, 1'b1, 4'd1,  16'hC000);
    issue("shr15_ffff", 16'hFFFF, 1'b0, 4'd15, 16'h0001);
    issue("shr0_ffff",  16'hFFFF, 1'b0, 4'd0,  16'hFFFF);
    issue("rot0_ffff",  16'hFFFF, 1'b1, 4'd0,  16'hFFFF);
    issue("rot15_0001", 16'h0001, 1'b1, 4'd15, 16'h0002);
    issue("rot4_1234",  16'h1234, 1'b1, 4'd4,  16'h4123);
    issue("shr4_1234",  16'h1234, 1'b0, 4'd4,  16'h0123);
    issue("rot8_1234",  16'h1234, 1'b1, 4'd8,  16'h3412);
    issue("shr15_8000", 16'h8000, 1'b0, 4'd15, 16'h0001);
    issue("rot1_a5a5",  16'hA5A5, 1'b1, 4'd1,  16'hD2D2);
    issue("rot0_0000",  16'h0000, 1'b1, 4'd0,  16'h0000);

    // Sweep src in steps of 5, cycling through every amount in both modes, vld_in held high.
    for (int i = 0; i * 5 <= 65535; i++) begin
      s = 16'(i * 5);
      a = 4'(i % 16);
      r = 1'((i / 16) % 2);
      issue("sweep", s, r, a, ref_model(s, r, a));
    end

    // Drain, then idle with changing src: result must hold and strobe stay low.
    idle(LAT + 2);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("idle_hold_res", bus.res, last_res);
      check("idle_vld", 16'(bus.vld_out), 16'h0000);
      bus.vld_in = 1'b0;
      bus.src    = 16'($urandom);
      bus.amt    = 4'($urandom);
    end

    // Reset mid-stream: in-flight results are lost, the operand under reset is discarded.
    issue("pre_rst_a", 16'hF00F, 1'b0, 4'd2, 16'h3C03);
    issue("pre_rst_b", 16'hF00F, 1'b1, 4'd2, 16'hFC03);
    @(negedge clk);
    rst        = 1'b1;
    bus.vld_in = 1'b1;
    bus.src    = 16'hFFFF;
    bus.rotate = 1'b1;
    bus.amt    = 4'd3;
    @(posedge clk);
    #2;
    q.delete();
    @(negedge clk);
    check("midrst_res", bus.res, 16'h0000);
    check("midrst_vld", 16'(bus.vld_out), 16'h0000);
    rst        = 1'b0;
    bus.vld_in = 1'b0;

    issue("post_rst_a", 16'h00F0, 1'b0, 4'd4, 16'h000F);
    issue("post_rst_b", 16'h000F, 1'b1, 4'd4, 16'hF000);
    issue("post_rst_c", 16'h8421, 1'b1, 4'd12, 16'h4218);
    idle(LAT + 4);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses: %0d results outstanding, expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
